ps2_key_tracker: RTL and testbench



---
 rtl/ps2_key_tracker.sv | 315 +++++++++++++++++++++++++++++++
 tb/tb_ps2_key_tracker.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_tracker.sv
// ps2_key_tracker -- PS/2 keyboard front end for the ship-control path.
//
// Pipeline: 2-flop synchronisers -> ps2c glitch filter -> frame receiver
// (parity/stop/timeout) -> make/break/E0 decoder -> held-key bitmap + event FIFO.
//
// Parameters
//   FILTER_LEN      ps2c filter length (>=2)
//   NUM_KEYS        number of tracked keys
//   KEY_CODES       NUM_KEYS x 9 bits, entry i = {ext, code} at [9i+8:9i]
//   FIFO_DEPTH      event FIFO entries (power of 2, >=2)
//   TIMEOUT_CYCLES  max clk cycles between sample strobes inside a frame
//
// Ports
//   clk, reset      system clock, synchronous active-high reset
//   ps2d, ps2c      raw PS/2 data/clock lines (asynchronous)
//   key_held        bit i set while key i is held
//   ev_valid/ev_ready/ev_code/ev_ext/ev_break  FWFT event FIFO head + handshake
//   ev_count        FIFO occupancy
//   overflow        sticky, set when an event is dropped
//   frame_err       one-cycle pulse per discarded frame
//
// Build option: define PS2_TYPEMATIC_FILTER_EN to keep typematic repeats of
// already-held mapped keys out of the FIFO (bitmap behaviour is unchanged).

// One tracked key: matches {ext, code} and keeps its held bit.
module ps2_key_slot #(
  parameter logic [8:0] CODE = 9'h000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ev_vld_i,
  input  logic       ev_brk_i,
  input  logic [8:0] ev_key_i,
  output logic       rpt_o,
  output logic       held_o
);
  logic hit;
  logic held_q;

  assign hit    = ev_vld_i && (ev_key_i == CODE);
  // Make on a key that is already down: a typematic repeat.
  assign rpt_o  = hit && !ev_brk_i && held_q;
  assign held_o = held_q;

  always_ff @(posedge clk) begin
    if (reset)    held_q <= 1'b0;
    else if (hit) held_q <= ~ev_brk_i;
  end
endmodule

module ps2_key_tracker #(
  parameter int                    FILTER_LEN     = 8,
  parameter int                    NUM_KEYS       = 9,
  parameter logic [NUM_KEYS*9-1:0] KEY_CODES      = {9'h174, 9'h172, 9'h16B, 9'h175,
                                                     9'h029, 9'h01D, 9'h01B, 9'h023, 9'h01C},
  parameter int                    FIFO_DEPTH     = 8,
  parameter int                    TIMEOUT_CYCLES = 50000
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          ps2d,
  input  logic                          ps2c,
  output logic [NUM_KEYS-1:0]           key_held,
  output logic                          ev_valid,
  input  logic                          ev_ready,
  output logic [7:0]                    ev_code,
  output logic                          ev_ext,
  output logic                          ev_break,
  output logic [$clog2(FIFO_DEPTH):0]   ev_count,
  output logic                          overflow,
  output logic                          frame_err
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef struct packed {
    logic       brk;
    logic       ext;
    logic [7:0] code;
  } ps2_ev_t;

  // ---------------------------------------------------------------- sync
  logic [1:0] c_sync_q, d_sync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      c_sync_q <= 2'b11;
      d_sync_q <= 2'b11;
    end else begin
      c_sync_q <= {c_sync_q[0], ps2c};
      d_sync_q <= {d_sync_q[0], ps2d};
    end
  end

  // ---------------------------------------------------------------- filter
  logic [FILTER_LEN-1:0] filt_q;
  logic                  fclk_q, fclk_d;
  logic                  strobe_q, sdat_q;

  // Hysteresis: only a full run of ones/zeros moves the filtered clock.
  always_comb begin
    fclk_d = fclk_q;
    if (&filt_q)       fclk_d = 1'b1;
    else if (~|filt_q) fclk_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      filt_q   <= '1;
      fclk_q   <= 1'b1;
      strobe_q <= 1'b0;
      sdat_q   <= 1'b1;
    end else begin
      filt_q   <= {filt_q[FILTER_LEN-2:0], c_sync_q[1]};
      fclk_q   <= fclk_d;
      // Data is captured with the strobe so both refer to the same edge.
      strobe_q <= fclk_q & ~fclk_d;
      sdat_q   <= d_sync_q[1];
    end
  end

  // ---------------------------------------------------------------- receiver
  typedef enum logic {RX_IDLE, RX_DATA} rx_state_e;

  rx_state_e       rx_state_q;
  logic [3:0]      bitcnt_q;
  logic [8:0]      rxsh_q;       // first nine bits: data[7:0], parity
  logic [9:0]      frame;        // complete frame on the 10th strobe
  logic [TW-1:0]   tcnt_q;
  logic            rx_vld_q;
  logic [7:0]      rx_byte_q;
  logic            frame_err_q;
  logic            frame_ok;

  assign frame    = {sdat_q, rxsh_q};
  assign frame_ok = frame[9] & (^frame[8:0]);

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_state_q  <= RX_IDLE;
      bitcnt_q    <= '0;
      rxsh_q      <= '0;
      tcnt_q      <= '0;
      rx_vld_q    <= 1'b0;
      rx_byte_q   <= '0;
      frame_err_q <= 1'b0;
    end else begin
      rx_vld_q    <= 1'b0;
      frame_err_q <= 1'b0;
      case (rx_state_q)
        RX_IDLE: begin
          tcnt_q   <= '0;
          bitcnt_q <= '0;
          if (strobe_q && !sdat_q) rx_state_q <= RX_DATA;
        end
        RX_DATA: begin
          if (strobe_q) begin
            tcnt_q   <= '0;
            rxsh_q   <= {sdat_q, rxsh_q[8:1]};
            bitcnt_q <= bitcnt_q + 4'd1;
            if (bitcnt_q == 4'd9) begin
              rx_state_q <= RX_IDLE;
              if (frame_ok) begin
                rx_vld_q  <= 1'b1;
                rx_byte_q <= frame[7:0];
              end else begin
                frame_err_q <= 1'b1;
              end
            end
          end else if (tcnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
            frame_err_q <= 1'b1;
            rx_state_q  <= RX_IDLE;
          end else begin
            tcnt_q <= tcnt_q + TW'(1);
          end
        end
        default: rx_state_q <= RX_IDLE;
      endcase
    end
  end

  assign frame_err = frame_err_q;

  // ---------------------------------------------------------------- decoder
  typedef enum logic [2:0] {DEC_BASE, DEC_E0, DEC_F0, DEC_E0F0, DEC_SKIP} dec_state_e;

  dec_state_e dec_q;
  logic [2:0] skip_q;
  logic       ev_fire;
  ps2_ev_t    ev_d;

  // Event is combinational off the registered byte so the bitmap and FIFO
  // commit on the very next edge.
  always_comb begin
    ev_d.code = rx_byte_q;
    ev_d.ext  = (dec_q == DEC_E0) || (dec_q == DEC_E0F0);
    ev_d.brk  = (dec_q == DEC_F0) || (dec_q == DEC_E0F0);
    ev_fire   = 1'b0;
    if (rx_vld_q) begin
      case (dec_q)
        DEC_BASE: begin
          case (rx_byte_q)
            // Prefixes and keyboard status/ack bytes.
            8'hE0, 8'hF0, 8'hE1,
            8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF: ev_fire = 1'b0;
            default:                                         ev_fire = 1'b1;
          endcase
        end
        DEC_E0:   ev_fire = (rx_byte_q != 8'hF0);
        DEC_F0,
        DEC_E0F0: ev_fire = 1'b1;
        default:  ev_fire = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dec_q  <= DEC_BASE;
      skip_q <= '0;
    end else if (rx_vld_q) begin
      case (dec_q)
        DEC_BASE: begin
          if (rx_byte_q == 8'hE0)      dec_q <= DEC_E0;
          else if (rx_byte_q == 8'hF0) dec_q <= DEC_F0;
          else if (rx_byte_q == 8'hE1) begin
            // Pause/Break: swallow the 7 bytes that follow E1.
            dec_q  <= DEC_SKIP;
            skip_q <= 3'd7;
          end
        end
        DEC_E0:   dec_q <= (rx_byte_q == 8'hF0) ? DEC_E0F0 : DEC_BASE;
        DEC_SKIP: begin
          skip_q <= skip_q - 3'd1;
          if (skip_q == 3'd1) dec_q <= DEC_BASE;
        end
        default:  dec_q <= DEC_BASE;
      endcase
    end
  end

  // ---------------------------------------------------------------- bitmap
  logic [NUM_KEYS-1:0] rpt;

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    ps2_key_slot #(
      .CODE (KEY_CODES[9*k +: 9])
    ) u_slot (
      .clk      (clk),
      .reset    (reset),
      .ev_vld_i (ev_fire),
      .ev_brk_i (ev_d.brk),
      .ev_key_i ({ev_d.ext, ev_d.code}),
      .rpt_o    (rpt[k]),
      .held_o   (key_held[k])
    );
  end

  logic repeat_make;
`ifdef PS2_TYPEMATIC_FILTER_EN
  assign repeat_make = |rpt;
`else
  logic unused_rpt;
  assign unused_rpt  = |rpt;
  assign repeat_make = 1'b0;
`endif

  // ---------------------------------------------------------------- FIFO
  ps2_ev_t          mem_q [FIFO_DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [CW-1:0]    cnt_q;
  logic             overflow_q;
  logic             push_req, push, pop, full, empty;
  ps2_ev_t          head;

  assign empty    = (cnt_q == '0);
  assign full     = (cnt_q == CW'(FIFO_DEPTH));
  assign push_req = ev_fire & ~repeat_make;
  assign pop      = ev_ready & ~empty;
  // A pop in the same cycle frees the slot a full FIFO would otherwise refuse.
  assign push     = push_req & (~full | pop);

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= ev_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      cnt_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wptr_q <= wptr_q + AW'(1);
      if (pop)  rptr_q <= rptr_q + AW'(1);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
      if (push_req && !push) overflow_q <= 1'b1;
    end
  end

  // Head is gated by valid so the outputs read 0 while empty / after reset.
  assign head     = mem_q[rptr_q];
  assign ev_valid = ~empty;
  assign ev_code  = ev_valid ? head.code : 8'h00;
  assign ev_ext   = ev_valid & head.ext;
  assign ev_break = ev_valid & head.brk;
  assign ev_count = cnt_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_ps2_key_tracker.sv
module tb_ps2_key_tracker;
  localparam int H = 12;  // half period of the PS/2 clock in system cycles
`ifdef PS2_TYPEMATIC_FILTER_EN
  localparam int EXP_FILL = 1;
`else
  localparam int EXP_FILL = 8;
`endif

  logic       clk = 1'b0;
  logic       reset, ps2d, ps2c, ev_ready;
  logic [8:0] key_held;
  logic       ev_valid, ev_ext, ev_break, overflow, frame_err;
  logic [7:0] ev_code;
  logic [3:0] ev_count;

  int checks = 0;
  int errors = 0;
  int ferr_cnt = 0;
  int ferr_base;

  ps2_key_tracker dut (
    .clk(clk), .reset(reset), .ps2d(ps2d), .ps2c(ps2c),
    .key_held(key_held), .ev_valid(ev_valid), .ev_ready(ev_ready),
    .ev_code(ev_code), .ev_ext(ev_ext), .ev_break(ev_break),
    .ev_count(ev_count), .overflow(overflow), .frame_err(frame_err)
  );

  always #10 clk = ~clk;

  // Counts cycles with frame_err high; a single pulse adds exactly one.
  always @(posedge clk) if (!reset && frame_err) ferr_cnt <= ferr_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic ps2_bit(input logic b);
    ps2d = b;
    repeat (H) @(posedge clk);
    ps2c = 1'b0;
    repeat (H) @(posedge clk);
    ps2c = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic bad_par);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit((~^b) ^ bad_par);
    ps2_bit(1'b1);
    repeat (20) @(posedge clk);
  endtask

  task automatic pop_chk(input string tag, input logic [7:0] code, input logic ext, input logic brk);
    @(negedge clk);
    chk({tag, "_valid"}, ev_valid, 1);
    chk({tag, "_code"},  ev_code,  code);
    chk({tag, "_ext"},   ev_ext,   ext);
    chk({tag, "_break"}, ev_break, brk);
    ev_ready = 1'b1;
    @(posedge clk);
    #1 ev_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1; ps2c = 1'b1; ps2d = 1'b1; ev_ready = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("rst_held",  key_held, 0);
    chk("rst_valid", ev_valid, 0);
    chk("rst_count", ev_count, 0);
    chk("rst_ovf",   overflow, 0);
    chk("rst_ferr",  frame_err, 0);
    chk("rst_code",  ev_code, 0);
    reset = 1'b0;
    repeat (5) @(posedge clk);

    // Pop on empty is ignored.
    @(negedge clk); ev_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); ev_ready = 1'b0;
    chk("empty_pop_count", ev_count, 0);
    chk("empty_pop_valid", ev_valid, 0);

    // Space make then break.
    send_byte(8'h29, 1'b0);
    @(negedge clk);
    chk("sp_make_held",  key_held, 9'h010);
    chk("sp_make_count", ev_count, 1);
    pop_chk("sp_make", 8'h29, 1'b0, 1'b0);
    send_byte(8'hF0, 1'b0);
    send_byte(8'h29, 1'b0);
    @(negedge clk);
    chk("sp_brk_held",  key_held, 9'h000);
    chk("sp_brk_count", ev_count, 1);
    pop_chk("sp_brk", 8'h29, 1'b0, 1'b1);
    @(negedge clk);
    chk("sp_drained", ev_count, 0);

    // w down, extended up make/break, w stays held, then w up.
    send_byte(8'h1D, 1'b0);
    pop_chk("w_make", 8'h1D, 1'b0, 1'b0);
    send_byte(8'hE0, 1'b0);
    send_byte(8'h75, 1'b0);
    @(negedge clk);
    chk("up_make_held", key_held, 9'h028);
    pop_chk("up_make", 8'h75, 1'b1, 1'b0);
    send_byte(8'hE0, 1'b0);
    send_byte(8'hF0, 1'b0);
    send_byte(8'h75, 1'b0);
    @(negedge clk);
    chk("up_brk_held", key_held, 9'h008);
    pop_chk("up_brk", 8'h75, 1'b1, 1'b1);
    send_byte(8'hF0, 1'b0);
    send_byte(8'h1D, 1'b0);
    @(negedge clk);
    chk("w_brk_held", key_held, 9'h000);
    pop_chk("w_brk", 8'h1D, 1'b0, 1'b1);

    // Bad parity, then an ignored status byte.
    ferr_base = ferr_cnt;
    send_byte(8'h1C, 1'b1);
    @(negedge clk);
    chk("par_ferr",  ferr_cnt - ferr_base, 1);
    chk("par_count", ev_count, 0);
    chk("par_held",  key_held, 0);
    send_byte(8'hAA, 1'b0);
    @(negedge clk);
    chk("aa_count", ev_count, 0);

    // Pause sequence swallowed; following d make decodes.
    send_byte(8'hE1, 1'b0); send_byte(8'h14, 1'b0); send_byte(8'h77, 1'b0);
    send_byte(8'hE1, 1'b0); send_byte(8'hF0, 1'b0); send_byte(8'h14, 1'b0);
    send_byte(8'hF0, 1'b0); send_byte(8'h77, 1'b0);
    @(negedge clk);
    chk("pause_count", ev_count, 0);
    send_byte(8'h23, 1'b0);
    @(negedge clk);
    chk("d_count", ev_count, 1);
    chk("d_held",  key_held, 9'h002);
    pop_chk("d_make", 8'h23, 1'b0, 1'b0);
    send_byte(8'hF0, 1'b0);
    send_byte(8'h23, 1'b0);
    pop_chk("d_brk", 8'h23, 1'b0, 1'b1);

    // Fill FIFO with a-key makes, no consumer.
    for (int i = 0; i < 8; i++) send_byte(8'h1C, 1'b0);
    @(negedge clk);
    chk("fill_count", ev_count, EXP_FILL);
    chk("fill_ovf",   overflow, 0);
    chk("fill_held",  key_held, 9'h001);
    send_byte(8'h1C, 1'b0);
    @(negedge clk);
    chk("ovf_count", ev_count, EXP_FILL);
    chk("ovf_flag",  overflow, (EXP_FILL == 8) ? 1 : 0);
    for (int i = 0; i < EXP_FILL; i++) pop_chk("drain", 8'h1C, 1'b0, 1'b0);
    @(negedge clk);
    chk("drain_count",  ev_count, 0);
    chk("ovf_sticky",   overflow, (EXP_FILL == 8) ? 1 : 0);

    // Truncated frame: start + 4 bits, then the clock stays idle.
    ferr_base = ferr_cnt;
    ps2_bit(1'b0);
    ps2_bit(1'b1); ps2_bit(1'b1); ps2_bit(1'b0); ps2_bit(1'b1);
    ps2d = 1'b1;
    repeat (49900) @(posedge clk);
    @(negedge clk);
    chk("tmo_early", ferr_cnt - ferr_base, 0);
    repeat (200) @(posedge clk);
    @(negedge clk);
    chk("tmo_fire",  ferr_cnt - ferr_base, 1);
    chk("tmo_count", ev_count, 0);
    send_byte(8'h1B, 1'b0);
    @(negedge clk);
    chk("s_held", key_held, 9'h005);
    pop_chk("s_make", 8'h1B, 1'b0, 1'b0);

    // Reset mid-frame aborts the partial frame and clears state.
    ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b0);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("mid_rst_held", key_held, 0);
    chk("mid_rst_ovf",  overflow, 0);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    send_byte(8'h29, 1'b0);
    @(negedge clk);
    chk("post_rst_held",  key_held, 9'h010);
    chk("post_rst_count", ev_count, 1);
    pop_chk("post_rst", 8'h29, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
